// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences the shared ALU and unified memory, decodes ALUControl and ImmSrc.
// Optional macro ILLEGAL_OP_TRAP_EN: an unknown opcode parks the FSM in HALT until reset.
module multicycle_controller #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Op,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        HALT     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_RT  = 7'b0110011;
    localparam logic [6:0] OP_IT  = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT);

    state_t           state_r;
    state_t           nextState_s;
    logic [CNT_W-1:0] waitCnt_r;
    logic             waitDone_s;
    logic             inWait_s;
    aluop_t           aluOp_s;
    logic             pcUpdate_s;
    logic             branch_s;
    logic             memWrite_s;
    logic             regWrite_s;

    // Subtract only for R-type sub; I-type funct3=000 is always addi.
    function automatic logic [2:0] aluDecode(input aluop_t aluOp, input logic [2:0] funct3,
                                             input logic opB5, input logic f7B5);
        logic [2:0] ctl;
        ctl = 3'b000;
        case (aluOp)
            ALU_ADD: ctl = 3'b000;
            ALU_SUB: ctl = 3'b001;
            ALU_FUNCT: begin
                case (funct3)
                    3'b000:  ctl = (opB5 & f7B5) ? 3'b001 : 3'b000;
                    3'b010:  ctl = 3'b101;
                    3'b110:  ctl = 3'b011;
                    3'b111:  ctl = 3'b010;
                    default: ctl = 3'b000;
                endcase
            end
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    function automatic logic [1:0] immDecode(input logic [6:0] op);
        logic [1:0] imm;
        imm = 2'b00;
        case (op)
            OP_LW, OP_IT: imm = 2'b00;
            OP_SW:        imm = 2'b01;
            OP_BEQ:       imm = 2'b10;
            OP_JAL:       imm = 2'b11;
            default:      imm = 2'b00;
        endcase
        return imm;
    endfunction

    assign inWait_s   = (state_r == FETCH) || (state_r == MEMREAD);
    assign waitDone_s = (waitCnt_r == WAIT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Memory wait counter: counts only in FETCH/MEMREAD and clears when the state is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt_r <= '0;
        end else if (inWait_s && !waitDone_s) begin
            waitCnt_r <= waitCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            waitCnt_r <= '0;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState_s = FETCH;
        case (state_r)
            FETCH:   nextState_s = waitDone_s ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: nextState_s = MEMADR;
                    OP_RT:        nextState_s = EXECUTER;
                    OP_IT:        nextState_s = EXECUTEI;
                    OP_BEQ:       nextState_s = BEQ;
                    OP_JAL:       nextState_s = JAL;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      nextState_s = HALT;
`else
                    default:      nextState_s = FETCH;
`endif
                endcase
            end
            MEMADR:   nextState_s = (Op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  nextState_s = waitDone_s ? MEMWB : MEMREAD;
            EXECUTER: nextState_s = ALUWB;
            EXECUTEI: nextState_s = ALUWB;
            JAL:      nextState_s = ALUWB;
            MEMWB:    nextState_s = FETCH;
            MEMWRITE: nextState_s = FETCH;
            ALUWB:    nextState_s = FETCH;
            BEQ:      nextState_s = FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            HALT:     nextState_s = HALT;
`else
            HALT:     nextState_s = FETCH;
`endif
            default:  nextState_s = FETCH;
        endcase
    end

    // Moore output decode; HALT and unused encodings fall through to all-zero.
    always_comb begin
        pcUpdate_s = 1'b0;
        branch_s   = 1'b0;
        memWrite_s = 1'b0;
        regWrite_s = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        aluOp_s    = ALU_ADD;
        case (state_r)
            FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                IRWrite    = waitDone_s;
                pcUpdate_s = waitDone_s;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc  = 2'b01;
                regWrite_s = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                memWrite_s = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                aluOp_s = ALU_FUNCT;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluOp_s = ALU_FUNCT;
            end
            ALUWB:    regWrite_s = 1'b1;
            BEQ: begin
                ALUSrcA  = 2'b10;
                aluOp_s  = ALU_SUB;
                branch_s = 1'b1;
            end
            JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pcUpdate_s = 1'b1;
            end
            default: begin
                pcUpdate_s = 1'b0;
            end
        endcase
    end

    // Architectural writes are suppressed while reset is held mid-instruction.
    assign MemWrite   = memWrite_s & ~reset;
    assign RegWrite   = regWrite_s & ~reset;
    assign PCWrite    = pcUpdate_s | (branch_s & Zero);
    assign ALUControl = aluDecode(aluOp_s, Funct3, Op[5], Funct7b5);
    assign ImmSrc     = immDecode(Op);
    assign State      = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller (MEM_WAIT=0 and MEM_WAIT=2 instances).
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] Op = 7'b0000000;
    logic [2:0] Funct3 = 3'b000;
    logic       Funct7b5 = 1'b0;
    logic       Zero = 1'b0;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    logic       PCWriteW, AdrSrcW, MemWriteW, IRWriteW, RegWriteW;
    logic [1:0] ResultSrcW, ALUSrcAW, ALUSrcBW, ImmSrcW;
    logic [2:0] ALUControlW;
    logic [3:0] StateW;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];

    // {State, IRWrite, MemWrite, RegWrite} per cycle on the MEM_WAIT=2 instance
    logic [6:0] swSeq [10] = '{7'b0000_000, 7'b0000_000, 7'b0000_100, 7'b0001_000, 7'b0010_000,
                               7'b0101_010, 7'b0000_000, 7'b0000_000, 7'b0000_100, 7'b0001_000};
    logic [6:0] lwSeq [10] = '{7'b0000_000, 7'b0000_000, 7'b0000_100, 7'b0001_000, 7'b0010_000,
                               7'b0011_000, 7'b0011_000, 7'b0011_000, 7'b0100_001, 7'b0000_000};

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_WAIT(0), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .State(State)
    );

    multicycle_controller #(.MEM_WAIT(2), .CNT_W(4)) dutW (
        .clk(clk), .reset(reset), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5), .Zero(Zero),
        .PCWrite(PCWriteW), .AdrSrc(AdrSrcW), .MemWrite(MemWriteW), .IRWrite(IRWriteW),
        .ResultSrc(ResultSrcW), .ALUSrcA(ALUSrcAW), .ALUSrcB(ALUSrcBW), .ImmSrc(ImmSrcW),
        .ALUControl(ALUControlW), .RegWrite(RegWriteW), .State(StateW)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // en = {IRWrite, PCWrite, MemWrite, RegWrite, AdrSrc}
    task automatic row(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                       input logic [3:0] st, input logic [4:0] en, input logic [1:0] res,
                       input logic [1:0] a, input logic [1:0] b, input logic [1:0] imm,
                       input logic [2:0] alu);
        vec_t v;
        v.op  = op;
        v.f3  = f3;
        v.f7  = f7;
        v.z   = z;
        v.exp = {st, en, res, a, b, imm, alu};
        tbl.push_back(v);
    endtask

    task automatic fd(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                      input logic [1:0] imm);
        row(op, f3, f7, z, 4'd0, 5'b11000, 2'b10, 2'b00, 2'b10, imm, 3'b000);
        row(op, f3, f7, z, 4'd1, 5'b00000, 2'b00, 2'b01, 2'b01, imm, 3'b000);
    endtask

    // Leaves the bench at a falling edge with reset released and both FSMs in FETCH.
    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic midReset(input string name, input logic [6:0] op, input int steps,
                            input logic [3:0] st);
        Op = op;
        Funct3 = 3'b000;
        Funct7b5 = 1'b0;
        Zero = 1'b0;
        repeat (steps) @(negedge clk);
        reset = 1'b1;
        #1;
        check({name, "_state"}, 32'(State), 32'(st));
        check({name, "_wr"}, 32'({MemWrite, RegWrite}), 32'd0);
        @(posedge clk);
        #1;
        check({name, "_fetch"}, 32'(State), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic runW(input string name, input logic [6:0] op, input logic [6:0] exp [10]);
        doReset();
        Op = op;
        Funct3 = 3'b010;
        Funct7b5 = 1'b0;
        Zero = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("%s_c%0d", name, c),
                  32'({StateW, IRWriteW, MemWriteW, RegWriteW}), 32'(exp[c]));
            @(negedge clk);
        end
    endtask

    initial begin
        fd(LW, 3'b010, 1'b0, 1'b0, 2'b00);
        row(LW, 3'b010, 1'b0, 1'b0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
        row(LW, 3'b010, 1'b0, 1'b0, 4'd3, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        row(LW, 3'b010, 1'b0, 1'b0, 4'd4, 5'b00010, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
        fd(RT, 3'b000, 1'b1, 1'b0, 2'b00);
        row(RT, 3'b000, 1'b1, 1'b0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
        row(RT, 3'b000, 1'b1, 1'b0, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        fd(IT, 3'b000, 1'b1, 1'b0, 2'b00);
        row(IT, 3'b000, 1'b1, 1'b0, 4'd7, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
        row(IT, 3'b000, 1'b1, 1'b0, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        fd(RT, 3'b111, 1'b0, 1'b0, 2'b00);
        row(RT, 3'b111, 1'b0, 1'b0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010);
        row(RT, 3'b111, 1'b0, 1'b0, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        fd(IT, 3'b110, 1'b1, 1'b0, 2'b00);
        row(IT, 3'b110, 1'b1, 1'b0, 4'd7, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011);
        row(IT, 3'b110, 1'b1, 1'b0, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        fd(RT, 3'b010, 1'b0, 1'b0, 2'b00);
        row(RT, 3'b010, 1'b0, 1'b0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101);
        row(RT, 3'b010, 1'b0, 1'b0, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        fd(RT, 3'b001, 1'b1, 1'b0, 2'b00);
        row(RT, 3'b001, 1'b1, 1'b0, 4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000);
        row(RT, 3'b001, 1'b1, 1'b0, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        fd(BQ, 3'b000, 1'b0, 1'b1, 2'b10);
        row(BQ, 3'b000, 1'b0, 1'b1, 4'd9, 5'b01000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
        fd(BQ, 3'b000, 1'b0, 1'b0, 2'b10);
        row(BQ, 3'b000, 1'b0, 1'b0, 4'd9, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
        fd(JL, 3'b000, 1'b0, 1'b0, 2'b11);
        row(JL, 3'b000, 1'b0, 1'b0, 4'd10, 5'b01000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000);
        row(JL, 3'b000, 1'b0, 1'b0, 4'd8, 5'b00010, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000);
        fd(SW, 3'b010, 1'b0, 1'b0, 2'b01);
        row(SW, 3'b010, 1'b0, 1'b0, 4'd2, 5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000);
        row(SW, 3'b010, 1'b0, 1'b0, 4'd5, 5'b00101, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);

        doReset();
        for (int i = 0; i < tbl.size(); i++) begin
            Op = tbl[i].op;
            Funct3 = tbl[i].f3;
            Funct7b5 = tbl[i].f7;
            Zero = tbl[i].z;
            #1;
            check($sformatf("vec%0d", i),
                  32'({State, IRWrite, PCWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
                       ALUSrcA, ALUSrcB, ImmSrc, ALUControl}), 32'(tbl[i].exp));
            @(negedge clk);
        end

        midReset("rst_sw", SW, 3, 4'd5);
        midReset("rst_r", RT, 3, 4'd8);
        midReset("rst_lw", LW, 4, 4'd4);

        runW("wait_sw", SW, swSeq);
        Op = SW;
        #1;
        check("wait_sw_imm", 32'(ImmSrcW), 32'd1);
        runW("wait_lw", LW, lwSeq);

        doReset();
        Op = BAD;
        Zero = 1'b1;
        #1;
        check("bad_fetch", 32'(State), 32'd0);
        @(negedge clk);
        #1;
        check("bad_decode", 32'(State), 32'd1);
        @(negedge clk);
`ifdef ILLEGAL_OP_TRAP_EN
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("halt_state_c%0d", c), 32'(State), 32'd11);
            check($sformatf("halt_en_c%0d", c),
                  32'({IRWrite, PCWrite, MemWrite, RegWrite}), 32'd0);
            @(negedge clk);
        end
`else
        #1;
        check("bad_nop", 32'(State), 32'd0);
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("bad_reset", 32'(State), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
